// File: rtl/signal_narrowing_pkg.sv
// signal_narrowing shared types and constants.
// Buffer states, width defaults and saturation builders.
package signal_narrowing_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  localparam int I_NBITS_DEF = 16;
  localparam int O_NBITS_DEF = 11;
  localparam int e_NBITS     = I_NBITS_DEF - O_NBITS_DEF;

  // Largest positive value of a w-bit signed field: 0 then ones.
  function automatic logic [31:0] sat_max(input int w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  // Most negative value of a w-bit signed field: 1 then zeros.
  function automatic logic [31:0] sat_min(input int w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/signal_narrowing_skid_buffer.sv
// Two-entry skid buffer with registered upstream ready.
// Output register plus skid register, EMPTY/BUSY/FULL.
module skid_buffer
  import signal_narrowing_pkg::*;
#(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] up_data,
  input  logic         up_valid,
  output logic         up_ready,
  output logic [W-1:0] dn_data,
  output logic         dn_valid,
  input  logic         dn_ready
);

  buf_state_t state, state_nxt;
  logic [W-1:0] main_q, skid_q;
  logic up_xfer, dn_xfer;
  logic load_main, load_skid, pop_skid;

  assign up_ready = (state != FULL);
  assign dn_valid = (state != EMPTY);
  assign dn_data  = main_q;
  assign up_xfer  = up_valid && up_ready;
  assign dn_xfer  = dn_valid && dn_ready;

  // Next state and which register captures data.
  always_comb begin
    state_nxt = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    pop_skid  = 1'b0;
    unique case (state)
      EMPTY: begin
        if (up_xfer) begin
          state_nxt = BUSY;
          load_main = 1'b1;
        end
      end
      BUSY: begin
        if (up_xfer && !dn_xfer) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (!up_xfer && dn_xfer) begin
          state_nxt = EMPTY;
        end else if (up_xfer && dn_xfer) begin
          load_main = 1'b1;
        end
      end
      FULL: begin
        if (dn_xfer) begin
          state_nxt = BUSY;
          pop_skid  = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Data registers; skid word refills the output on drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)     main_q <= up_data;
      else if (pop_skid) main_q <= skid_q;
      if (load_skid)     skid_q <= up_data;
    end
  end

endmodule

// File: rtl/signal_narrowing.sv
// Narrows a wide signed sample with saturate/wrap.
// Registered behind a skid buffer; tracks overflow.
module signal_narrowing
  import signal_narrowing_pkg::*;
#(
  parameter int i_NBITS   = 16,
  parameter int o_NBITS   = 11,
  parameter int CNT_NBITS = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [i_NBITS-1:0]   i_signal,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_sat_enable,
  output logic [o_NBITS-1:0]   o_narrow_signal,
  output logic                 o_ovf,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_ovf_sticky,
  output logic [CNT_NBITS-1:0] o_ovf_count,
  input  logic                 i_clear_sticky
);

  localparam int TOP_W = i_NBITS - o_NBITS + 1;

  localparam logic [o_NBITS-1:0] SAT_HI = o_NBITS'(sat_max(o_NBITS));
  localparam logic [o_NBITS-1:0] SAT_LO = o_NBITS'(sat_min(o_NBITS));

  logic [TOP_W-1:0]   top_bits;
  logic               fit, ovf, accept;
  logic [o_NBITS-1:0] narrow;
  logic [o_NBITS:0]   buf_out;

  assign top_bits = i_signal[i_NBITS-1:o_NBITS-1];
  assign fit      = (&top_bits) | ~(|top_bits);
  assign ovf      = !fit;
  assign accept   = i_valid && o_ready;

  // Saturate toward the input's sign, else keep low bits.
  always_comb begin
    narrow = i_signal[o_NBITS-1:0];
    if (ovf && i_sat_enable)
      narrow = i_signal[i_NBITS-1] ? SAT_LO : SAT_HI;
  end

  skid_buffer #(
    .W (o_NBITS + 1)
  ) u_buf (
    .clk      (i_clock),
    .rst      (i_reset),
    .up_data  ({ovf, narrow}),
    .up_valid (i_valid),
    .up_ready (o_ready),
    .dn_data  (buf_out),
    .dn_valid (o_valid),
    .dn_ready (i_ready)
  );

  assign o_ovf           = buf_out[o_NBITS];
  assign o_narrow_signal = buf_out[o_NBITS-1:0];

  // Sticky flag and saturating count; an event beats a clear.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_ovf_sticky <= 1'b0;
      o_ovf_count  <= '0;
    end else if (accept && ovf) begin
      o_ovf_sticky <= 1'b1;
      if (i_clear_sticky)
        o_ovf_count <= CNT_NBITS'(1);
      else if (!(&o_ovf_count))
        o_ovf_count <= o_ovf_count + 1'b1;
    end else if (i_clear_sticky) begin
      o_ovf_sticky <= 1'b0;
      o_ovf_count  <= '0;
    end
  end

endmodule
